// File: rtl/mini_cpu_pkg.sv
// Shared Mini-CPU definitions: OPTION register layout, reset values, TMR0 address
// and the power-of-two ratio helpers used by the shared prescaler.
package mini_cpu_pkg;

  localparam int OPT_T0CS = 5;
  localparam int OPT_T0SE = 4;
  localparam int OPT_PSA  = 3;
  localparam int OPT_PS_MSB = 2;
  localparam int OPT_PS_LSB = 0;

  localparam logic [5:0] OPTION_RST   = 6'h3F;
  localparam logic [4:0] TMR0_ADRS    = 5'h01;
  localparam logic [1:0] TMR0_INHIBIT = 2'd2;

  typedef struct packed {
    logic       t0cs;
    logic       t0se;
    logic       psa;
    logic [2:0] ps;
  } option_t;

  // Ones in bits [log2_ratio-1:0]; log2_ratio ranges 0..8.
  function automatic logic [7:0] ratio_mask(input logic [3:0] log2_ratio);
    logic [8:0] m;
    m = (9'd1 << log2_ratio) - 9'd1;
    return m[7:0];
  endfunction

  // True when the low log2_ratio bits of count are all ones (0 bits -> always true).
  function automatic logic ratio_hit(input logic [7:0] count, input logic [3:0] log2_ratio);
    return (count & ratio_mask(log2_ratio)) == ratio_mask(log2_ratio);
  endfunction

endpackage

// File: rtl/t0cki_sync.sv
// T0CKI pin synchronizer: two metastability flops, one history flop and a
// selectable edge detector producing a single-cycle pulse.
module t0cki_sync (
  input  logic clk,
  input  logic rst,
  input  logic t0cki,
  input  logic t0se,
  output logic edge_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  always_comb begin
    sync1_d = t0cki;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  // t0se=0 selects rising edges, t0se=1 falling edges.
  always_comb begin
    if (t0se) edge_pulse = hist_q & ~sync2_q;
    else      edge_pulse = ~hist_q & sync2_q;
  end

endmodule

// File: rtl/tmr0_wdt_ctrl.sv
// Timing source for the Mini-CPU: OPTION register, TMR0 increment strobe,
// shared prescaler and watchdog base counter with timeout strobe.
module tmr0_wdt_ctrl
  import mini_cpu_pkg::*;
#(
  parameter int WDT_PERIOD = 1024,
  parameter int WDT_W      = $clog2(WDT_PERIOD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       option_wr,
  input  logic [5:0] option_data,
  input  logic       tmr0_wr,
  input  logic       clrwdt,
  input  logic       sleep,
  input  logic       asleep,
  input  logic       wdt_en,
  input  logic       t0cki,
  output logic       tmr0_inc,
  output logic       wdtmr,
  output logic [5:0] option_q
);

  logic [5:0]       option_d;
  logic [7:0]       presc_q, presc_d;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic [1:0]       inhibit_q, inhibit_d;
  logic             tmr0_inc_q, tmr0_inc_d;
  logic             wdtmr_q, wdtmr_d;

  option_t    opt;
  logic       ext_edge;
  logic       src_tick;
  logic       wdt_clr;
  logic       wdt_term;
  logic       base_tick;
  logic       psa_change;
  logic       presc_clr;
  logic [7:0] presc_inc;
  logic       tmr0_hit;
  logic       wdt_hit;

  assign opt = option_t'(option_q);

  t0cki_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .t0cki      (t0cki),
    .t0se       (opt.t0se),
    .edge_pulse (ext_edge)
  );

  // Ticks are discarded in the TMR0 write cycle and while the inhibit count runs down.
  always_comb begin
    src_tick = (opt.t0cs ? ext_edge : 1'b1) & ~asleep & ~tmr0_wr & (inhibit_q == 2'd0);
  end

  always_comb begin
    wdt_clr    = clrwdt | sleep;
    wdt_term   = (wdt_cnt_q == WDT_W'(WDT_PERIOD - 1));
    base_tick  = wdt_en & ~wdt_clr & wdt_term;
    psa_change = option_wr & (option_data[OPT_PSA] != opt.psa);
    presc_clr  = (wdt_clr & opt.psa) | (tmr0_wr & ~opt.psa) | psa_change;
    presc_inc  = presc_q + 8'd1;
    tmr0_hit   = ratio_hit(presc_inc, {1'b0, opt.ps} + 4'd1);
    wdt_hit    = ratio_hit(presc_inc, {1'b0, opt.ps});
  end

  always_comb begin
    option_d = option_wr ? option_data : option_q;

    inhibit_d = inhibit_q;
    if (tmr0_wr)                 inhibit_d = TMR0_INHIBIT;
    else if (inhibit_q != 2'd0)  inhibit_d = inhibit_q - 2'd1;

    wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    if (!wdt_en || wdt_clr || wdt_term) wdt_cnt_d = '0;

    // A clear in the same cycle wins over the tick that would have advanced it.
    presc_d = presc_q;
    if (presc_clr)                                        presc_d = 8'd0;
    else if ((!opt.psa && src_tick) || (opt.psa && base_tick)) presc_d = presc_inc;
  end

  always_comb begin
    if (opt.psa) begin
      tmr0_inc_d = src_tick;
      wdtmr_d    = base_tick & ~presc_clr & wdt_hit;
    end else begin
      tmr0_inc_d = src_tick & ~presc_clr & tmr0_hit;
      wdtmr_d    = base_tick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      option_q   <= OPTION_RST;
      presc_q    <= 8'd0;
      wdt_cnt_q  <= '0;
      inhibit_q  <= 2'd0;
      tmr0_inc_q <= 1'b0;
      wdtmr_q    <= 1'b0;
    end else begin
      option_q   <= option_d;
      presc_q    <= presc_d;
      wdt_cnt_q  <= wdt_cnt_d;
      inhibit_q  <= inhibit_d;
      tmr0_inc_q <= tmr0_inc_d;
      wdtmr_q    <= wdtmr_d;
    end
  end

  assign tmr0_inc = tmr0_inc_q;
  assign wdtmr    = wdtmr_q;

endmodule

// File: tb/tb_tmr0_wdt_ctrl.sv
// Bench for tmr0_wdt_ctrl: directed scenarios followed by random traffic, checked
// every cycle against an arithmetic reference model of the timer/watchdog rules.
module tb_tmr0_wdt_ctrl;

  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rst, option_wr, tmr0_wr, clrwdt, sleep, asleep, wdt_en, t0cki;
  logic [5:0] option_data, option_q;
  logic       tmr0_inc, wdtmr;

  int n_assert = 0;
  int n_fail   = 0;
  int inc_cnt, wdt_cnt;

  // Reference model state (values visible in the current cycle).
  logic [5:0] m_opt;
  int         m_presc, m_age, m_since_wr;
  logic       m_pins[$];
  logic       m_inc, m_wdtmr;

  always #5 clk = ~clk;

  tmr0_wdt_ctrl #(.WDT_PERIOD(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .option_wr   (option_wr),
    .option_data (option_data),
    .tmr0_wr     (tmr0_wr),
    .clrwdt      (clrwdt),
    .sleep       (sleep),
    .asleep      (asleep),
    .wdt_en      (wdt_en),
    .t0cki       (t0cki),
    .tmr0_inc    (tmr0_inc),
    .wdtmr       (wdtmr),
    .option_q    (option_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Evaluate the model on the current inputs, advance one clock, compare.
  task automatic tick();
    logic [5:0] n_opt;
    int   n_presc, n_age, n_since, ps, ratio_t, ratio_w;
    logic n_inc, n_wdtmr, psa, ext, src, clr, base, pclr, s2, s3;
    if (rst) begin
      n_opt = 6'h3F; n_presc = 0; n_age = 0; n_since = 3; n_inc = 0; n_wdtmr = 0;
    end else begin
      psa     = m_opt[3];
      ps      = int'(m_opt[2:0]);
      ratio_t = 1 << (ps + 1);
      ratio_w = 1 << ps;
      s3      = m_pins[0];
      s2      = m_pins[1];
      ext     = m_opt[4] ? (s3 && !s2) : (!s3 && s2);
      src     = (m_opt[5] ? ext : 1'b1) && !asleep && !tmr0_wr && (m_since_wr >= 3);
      clr     = clrwdt || sleep;
      base    = wdt_en && !clr && ((m_age % P) == P - 1);
      pclr    = (clr && psa) || (tmr0_wr && !psa) || (option_wr && (option_data[3] != psa));
      n_inc   = psa ? src : (src && !pclr && (((m_presc + 1) % ratio_t) == ratio_t - 1));
      n_wdtmr = psa ? (base && !pclr && (((m_presc + 1) % ratio_w) == ratio_w - 1)) : base;
      if (pclr) n_presc = 0;
      else if ((!psa && src) || (psa && base)) n_presc = (m_presc + 1) % 256;
      else n_presc = m_presc;
      n_age   = (!wdt_en || clr) ? 0 : m_age + 1;
      n_since = tmr0_wr ? 1 : ((m_since_wr >= 3) ? 3 : m_since_wr + 1);
      n_opt   = option_wr ? option_data : m_opt;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_pins.delete();
      m_pins.push_back(1'b0); m_pins.push_back(1'b0); m_pins.push_back(1'b0);
    end else begin
      m_pins.push_back(t0cki);
      void'(m_pins.pop_front());
    end
    m_opt = n_opt; m_presc = n_presc; m_age = n_age; m_since_wr = n_since;
    m_inc = n_inc; m_wdtmr = n_wdtmr;
    chk("tmr0_inc", 32'(tmr0_inc), 32'(m_inc));
    chk("wdtmr",    32'(wdtmr),    32'(m_wdtmr));
    chk("option_q", 32'(option_q), 32'(m_opt));
    chk("presc",    32'(dut.presc_q), 32'(m_presc));
    if (tmr0_inc === 1'b1) inc_cnt++;
    if (wdtmr === 1'b1)    wdt_cnt++;
    option_wr = 1'b0; tmr0_wr = 1'b0; clrwdt = 1'b0; sleep = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_opt(input logic [5:0] d);
    option_data = d;
    option_wr   = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; option_wr = 1'b0; tmr0_wr = 1'b0; clrwdt = 1'b0; sleep = 1'b0;
    asleep = 1'b0; wdt_en = 1'b1; t0cki = 1'b0; option_data = 6'h00;
    m_opt = 6'h3F; m_presc = 0; m_age = 0; m_since_wr = 3; m_inc = 0; m_wdtmr = 0;
    m_pins.push_back(1'b0); m_pins.push_back(1'b0); m_pins.push_back(1'b0);
    inc_cnt = 0; wdt_cnt = 0;

    // Reset values
    run(3);
    chk("reset_option", 32'(option_q), 32'h3F);
    chk("reset_inc", 32'(tmr0_inc), 0);
    rst = 1'b0;

    // Internal clock, prescaler on WDT: TMR0 at 1:1
    set_opt(6'b001000);
    run(2);
    inc_cnt = 0;
    run(8);
    chk("ratio1_count", 32'(inc_cnt), 8);

    // Internal clock, prescaler on TMR0 at 1:8
    set_opt(6'b000010);
    run(2);
    inc_cnt = 0;
    run(64);
    chk("ratio8_count", 32'(inc_cnt), 8);

    // TMR0 write: three quiet output cycles, then counting restarts
    inc_cnt = 0;
    tmr0_wr = 1'b1;
    tick();
    run(2);
    chk("inhibit_window", 32'(inc_cnt), 0);
    inc_cnt = 0;
    run(8);
    chk("post_inhibit_one", 32'(inc_cnt), 1);
    run(12);

    // External clock, rising then falling edges, 1:2
    set_opt(6'b100000);
    for (int i = 0; i < 80; i++) begin
      if (i % 5 == 0) t0cki = ~t0cki;
      tick();
    end
    set_opt(6'b110000);
    for (int i = 0; i < 80; i++) begin
      if (i % 5 == 0) t0cki = ~t0cki;
      tick();
    end

    // Unscaled WDT with a CLRWDT in the middle
    set_opt(6'b000000);
    run(10);
    clrwdt = 1'b1;
    tick();
    run(40);

    // WDT through prescaler 1:4 -> one timeout per 64 cycles
    set_opt(6'b001010);
    run(20);
    wdt_cnt = 0;
    run(128);
    chk("wdt_64_period", 32'(wdt_cnt), 2);

    // Sleep: TMR0 frozen, WDT still times out 64 cycles later
    sleep = 1'b1; asleep = 1'b1;
    inc_cnt = 0; wdt_cnt = 0;
    tick();
    run(69);
    chk("sleep_no_inc", 32'(inc_cnt), 0);
    chk("sleep_wdt_once", 32'(wdt_cnt), 1);
    asleep = 1'b0;
    run(5);

    // PSA 0->1 switch clears the prescaler mid-count
    set_opt(6'b000111);
    run(50);
    set_opt(6'b001111);
    chk("psa_switch_presc", 32'(dut.presc_q), 0);

    // CLRWDT coincident with terminal count suppresses the timeout
    set_opt(6'b001000);
    for (int i = 0; i < P; i++) begin
      if ((m_age % P) == P - 1) break;
      tick();
    end
    clrwdt = 1'b1;
    tick();
    chk("clr_at_terminal", 32'(wdtmr), 0);
    chk("clr_presc", 32'(dut.presc_q), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 499) == 0);
      option_wr   = ($urandom_range(0, 39) == 0);
      option_data = 6'($urandom_range(0, 63));
      tmr0_wr     = ($urandom_range(0, 29) == 0);
      clrwdt      = ($urandom_range(0, 59) == 0);
      sleep       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0)  asleep = ~asleep;
      if ($urandom_range(0, 149) == 0) wdt_en = ~wdt_en;
      if ($urandom_range(0, 3) == 0)   t0cki  = ~t0cki;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr0_wdt_ctrl.md
Name: tmr0_wdt_ctrl

Overview:
- Timing-source block for the Mini-CPU.
- Produces the `tmr0_inc` increment strobe and the `wdtmr` watchdog-timeout strobe that the register file consumes.
- Owns the OPTION register (clock select, edge select, prescaler assignment, prescale ratio), the external T0CKI synchronizer, the shared 8-bit prescaler and the watchdog base counter.
- Sits beside the register file; its outputs drive the register file's TMR0 counter and the TO_N status bit.

Parameters:
- WDT_PERIOD, 1024, number of `clk` cycles per unscaled watchdog period (must be >= 2).
- WDT_W, $clog2(WDT_PERIOD), width of the watchdog base counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- option_wr  in  1  OPTION instruction strobe; loads `option_data`
- option_data  in  6  {T0CS, T0SE, PSA, PS[2:0]}
- tmr0_wr  in  1  file write to TMR0 (`f_wr` & `f_adrs`==5'h01), decoded by the core
- clrwdt  in  1  CLRWDT instruction strobe
- sleep  in  1  SLEEP instruction strobe
- asleep  in  1  level, core in sleep state
- wdt_en  in  1  watchdog enable (configuration fuse)
- t0cki  in  1  external TMR0 clock pin, asynchronous
- tmr0_inc  out  1  one-cycle increment request to TMR0
- wdtmr  out  1  one-cycle watchdog timeout pulse
- option_q  out  6  current OPTION value

Behaviour:
- Reset: `option_q`=6'b111111, prescaler=0, WDT counter=0, sync flops=0, inhibit counter=0, `tmr0_inc`=0, `wdtmr`=0.
- OPTION: on `option_wr`, `option_q` <= `option_data` at the next edge. If PSA changes, the prescaler clears in the same edge.
- Source tick (`src_tick`), combinational from registered state:
  - T0CS=0: `src_tick`=1 every cycle.
  - T0CS=1: `t0cki` passes a 2-flop synchronizer plus a third history flop. `src_tick`=1 on a synchronized rising edge when T0SE=0, or a falling edge when T0SE=1.
  - Source-to-TMR0 latency is 3 clk from the pin.
- Sleep and inhibit: `src_tick` is forced to 0 while `asleep`=1 or while the TMR0 inhibit counter is nonzero.
- TMR0 write:
  - `tmr0_wr` loads the inhibit counter with 2.
  - It decrements to 0 on each subsequent cycle.
  - Discarded ticks do not advance the prescaler.
  - If PSA=0, the prescaler also clears.
  - `tmr0_inc` is 0 during the write cycle and the following 2 cycles.
- PSA=0 (prescaler on TMR0):
  - The prescaler counts `src_tick`.
  - `tmr0_inc` pulses on the cycle after a tick that makes prescaler[PS:0] all ones, giving ratio 2^(PS+1) (1:2..1:256).
  - The WDT runs unscaled.
- PSA=1 (prescaler on WDT):
  - `tmr0_inc` is `src_tick` registered by 1 cycle, ratio 1:1.
  - The prescaler counts WDT base ticks at ratio 2^PS (1:1..1:128). PS=0 means pass-through.
- `tmr0_inc` is a registered output. With T0CS=0, PSA=1 and no inhibit, it is continuously 1.
- WDT base counter:
  - Counts 0..WDT_PERIOD-1 when `wdt_en`=1, including while `asleep`.
  - At terminal count it wraps to 0 and emits a base tick.
  - The scaled tick sets `wdtmr` for exactly 1 cycle, registered.
  - After a timeout the counter continues from 0.
- `clrwdt` or `sleep`:
  - Clears the WDT base counter.
  - Clears the prescaler if PSA=1.
  - Suppresses any timeout due in the same cycle.
- Priority: `rst` > (`clrwdt` | `sleep`) > `tmr0_wr`/`option_wr` clears > counting.
- `wdt_en`=0: WDT counter held at 0, `wdtmr`=0. The prescaler still serves TMR0 when PSA=0.
- Prescaler wraps modulo 256; no saturation.
- Simultaneous `tmr0_wr` and `option_wr`: both take effect. The prescaler clears if either clear condition holds.

Decomposition:
- Shared package mini_cpu_pkg:
  - OPTION bit indices (T0CS=5, T0SE=4, PSA=3, PS=2:0).
  - OPTION_RST=6'h3F.
  - TMR0_ADRS=5'h01.
  - TMR0_INHIBIT=2.
- Sub-module t0cki_sync: 2-flop synchronizer, history flop, edge select by T0SE; outputs a one-cycle edge pulse.

Test Plan:
- Reset, then T0CS=0, PSA=1 -> `tmr0_inc`=1 every cycle from the 2nd cycle after reset release; `option_q`=6'h3F at reset.
- `option_data`=6'b000010 (internal, PSA=0, 1:8), 64 cycles -> exactly 8 `tmr0_inc` pulses, 8 cycles apart; `tmr0_wr` mid-run -> next pulse 8 ticks after the inhibit ends, none in the 3-cycle window.
- `option_data`=6'b100000 (T0CKI, rising, 1:2), toggle `t0cki` every 5 clk -> `tmr0_inc` every 2nd rising edge, 3 clk after the pin edge; T0SE=1 -> counts falling edges instead.
- WDT_PERIOD=16, `wdt_en`=1, PSA=0 -> `wdtmr` pulses at cycles 16, 32, 48; `clrwdt` at cycle 30 -> next pulse at cycle 46.
- WDT_PERIOD=16, `option_data`=6'b001010 (PSA=1, 1:4) -> `wdtmr` every 64 cycles; `sleep` with `asleep`=1 -> `tmr0_inc` stays 0 and the WDT timeout still fires 64 cycles after `sleep`.
- PSA switched 0->1 via `option_wr` mid-count, and `clrwdt` coincident with a terminal count -> prescaler reads 0, no `wdtmr` pulse in that cycle.
